// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the program-counter sequencer.
//   PC_OP_W  width of the pc_op operation code
//   pc_op_e  operation encodings; code 7 is reserved and behaves as HOLD
package pc_seq_pkg;

  localparam int PC_OP_W = 3;

  typedef enum logic [PC_OP_W-1:0] {
    HOLD       = 3'd0,
    INC        = 3'd1,
    LOAD_IMM   = 3'd2,
    LOAD_REG   = 3'd3,
    BRANCH_REL = 3'd4,
    CALL       = 3'd5,
    RET        = 3'd6
  } pc_op_e;

endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: return-address LIFO (PC_W x STACK_DEPTH).
//   clk, rstn   clock, asynchronous active-low reset (clears depth only)
//   push        write push_data on top (ignored when full)
//   pop         discard top entry (ignored when empty)
//   push_data   return address to store
//   top         most recently pushed entry (undefined when empty)
//   full, empty depth == STACK_DEPTH / depth == 0
module pc_ret_stack #(
  parameter int PC_W        = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);
  import pc_seq_pkg::*;

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = $clog2(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

  logic [PC_W-1:0]    mem [STACK_DEPTH];
  logic [DEPTH_W-1:0] depth_p0;
  logic [DEPTH_W-1:0] depth_m1;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;

  assign depth_m1 = depth_p0 - DEPTH_ONE;
  assign wr_idx   = depth_p0[IDX_W-1:0];
  assign rd_idx   = depth_m1[IDX_W-1:0];

  assign full  = (depth_p0 == DEPTH_MAX);
  assign empty = (depth_p0 == '0);
  assign top   = mem[rd_idx];

  // ---- stage p0: depth counter (control, reset) ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      depth_p0 <= '0;
    end else if (push && !full) begin
      depth_p0 <= depth_p0 + DEPTH_ONE;
    end else if (pop && !empty) begin
      depth_p0 <= depth_m1;
    end
  end

  // ---- stage p0: entry storage (data, never reset) ----
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the fetch stage.
//   clk, rstn   clock, asynchronous active-low reset
//   stall       freezes PC, return stack and stack_err for this cycle
//   pc_op       operation (pc_seq_pkg::pc_op_e), cond qualifies BRANCH_REL
//   immediate   zero-extended for LOAD_IMM, sign-extended for BRANCH_REL
//   rd_data     register target for LOAD_REG and CALL
//   pc_out      registered program counter / instruction-memory address
//   stack_full, stack_empty  return-stack occupancy flags
//   stack_err   sticky: CALL while full or RET while empty; cleared by reset
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W        = 16,
  parameter int              IMM_W       = 8,
  parameter int              STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_VEC   = '0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               stall,
  input  logic [PC_OP_W-1:0] pc_op,
  input  logic               cond,
  input  logic [IMM_W-1:0]   immediate,
  input  logic [PC_W-1:0]    rd_data,
  output logic [PC_W-1:0]    pc_out,
  output logic               stack_full,
  output logic               stack_empty,
  output logic               stack_err
);

  function automatic logic [PC_W-1:0] zext(input logic [IMM_W-1:0] v);
    return {{(PC_W-IMM_W){1'b0}}, v};
  endfunction

  function automatic logic signed [PC_W-1:0] sext(input logic signed [IMM_W-1:0] v);
    return {{(PC_W-IMM_W){v[IMM_W-1]}}, v};
  endfunction

  logic [PC_W-1:0] pc_p0;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] stk_top;
  logic            err_p0;
  logic            err_d;
  logic            push;
  logic            pop;

  pc_ret_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  // Wraps modulo 2^PC_W; the pushed return address is this same value.
  assign pc_inc = pc_p0 + PC_W'(1);

  always_comb begin
    pc_d  = pc_p0;
    err_d = err_p0;
    push  = 1'b0;
    pop   = 1'b0;
    if (!stall) begin
      case (pc_op)
        INC:        pc_d = pc_inc;
        LOAD_IMM:   pc_d = zext(immediate);
        LOAD_REG:   pc_d = rd_data;
        BRANCH_REL: pc_d = cond ? (pc_p0 + sext(immediate)) : pc_inc;
        CALL: begin
          if (stack_full) begin
            err_d = 1'b1;
          end else begin
            push = 1'b1;
            pc_d = rd_data;
          end
        end
        RET: begin
          if (stack_empty) begin
            err_d = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_d = stk_top;
          end
        end
        default: ;
      endcase
    end
  end

  // ---- stage p0: PC and sticky fault register ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_p0  <= RESET_VEC;
      err_p0 <= 1'b0;
    end else begin
      pc_p0  <= pc_d;
      err_p0 <= err_d;
    end
  end

  assign pc_out    = pc_p0;
  assign stack_err = err_p0;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  pc_op = 3'd0;
  logic        cond = 1'b0;
  logic [7:0]  immediate = 8'h00;
  logic [15:0] rd_data = 16'h0000;
  logic [15:0] pc_out;
  logic        stack_full;
  logic        stack_empty;
  logic        stack_err;

  pc_sequencer dut (
    .clk         (clk),
    .rstn        (rstn),
    .stall       (stall),
    .pc_op       (pc_op),
    .cond        (cond),
    .immediate   (immediate),
    .rd_data     (rd_data),
    .pc_out      (pc_out),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic        full;
    logic        empty;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  bit   done = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Issue one op at the falling edge; its result is checked after the next rising edge.
  task automatic do_op(input logic st, input logic [2:0] op, input logic c,
                       input logic [7:0] imm, input logic [15:0] rd,
                       input logic [15:0] ep, input logic ef, input logic ee,
                       input logic er, input string nm);
    exp_t e;
    @(negedge clk);
    stall = st; pc_op = op; cond = c; immediate = imm; rd_data = rd;
    e.pc = ep; e.full = ef; e.empty = ee; e.err = er; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #2;
    stall = 1'b0; pc_op = 3'd0; cond = 1'b0;
  endtask

  // Drop rstn between edges and expect the reset state right away.
  task automatic async_reset(input string nm);
    exp_t e;
    @(negedge clk);
    #2;
    rstn = 1'b0;
    e.pc = 16'h0000; e.full = 1'b0; e.empty = 1'b1; e.err = 1'b0; e.name = nm;
    sb.push_back(e);
    -> sample_ev;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Monitor: compares every queued expectation against the DUT outputs.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk or sample_ev);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (pc_out !== e.pc || stack_full !== e.full ||
            stack_empty !== e.empty || stack_err !== e.err) begin
          n_fail++;
          $display("FAIL %s: got pc=%h full=%b empty=%b err=%b, expected pc=%h full=%b empty=%b err=%b",
                   e.name, pc_out, stack_full, stack_empty, stack_err,
                   e.pc, e.full, e.empty, e.err);
        end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

  // Driver: directed vectors with hand-computed expectations.
  initial begin
    // reset held low, even with INC requested
    do_op(0, INC, 0, 8'h00, 16'h0000, 16'h0000, 0, 1, 0, "reset_hold");
    release_reset();
    // stalled RET on empty must not raise the fault
    do_op(1, RET, 0, 8'h00, 16'h0000, 16'h0000, 0, 1, 0, "stall_ret_empty");

    do_op(0, LOAD_IMM, 0, 8'h05, 16'h0000, 16'h0005, 0, 1, 0, "load_imm");
    do_op(0, LOAD_REG, 0, 8'h00, 16'h0008, 16'h0008, 0, 1, 0, "load_reg");
    for (int i = 0; i < 10; i++)
      do_op(0, INC, 0, 8'h00, 16'h0000, 16'(16'h0009 + i), 0, 1, 0, $sformatf("inc%0d", i));
    do_op(0, BRANCH_REL, 1, 8'hFC, 16'h0000, 16'h000E, 0, 1, 0, "branch_taken");
    do_op(0, BRANCH_REL, 0, 8'hFC, 16'h0000, 16'h000F, 0, 1, 0, "branch_not_taken");
    do_op(0, LOAD_REG, 0, 8'h00, 16'hFFFF, 16'hFFFF, 0, 1, 0, "load_ffff");
    do_op(0, INC, 0, 8'h00, 16'h0000, 16'h0000, 0, 1, 0, "wrap");
    do_op(0, LOAD_IMM, 0, 8'h20, 16'h0000, 16'h0020, 0, 1, 0, "load_20");
    do_op(0, 3'd7, 1, 8'h55, 16'h1234, 16'h0020, 0, 1, 0, "reserved_op");

    do_op(0, CALL, 0, 8'h00, 16'h0100, 16'h0100, 0, 0, 0, "call");
    do_op(0, RET, 0, 8'h00, 16'h0000, 16'h0021, 0, 1, 0, "ret");

    for (int i = 0; i < 8; i++)
      do_op(0, CALL, 0, 8'h00, 16'(16'h1000 + i * 16), 16'(16'h1000 + i * 16),
            (i == 7), 0, 0, $sformatf("nest_call%0d", i));
    do_op(0, CALL, 0, 8'h00, 16'h2000, 16'h1070, 1, 0, 1, "call_on_full");
    for (int j = 0; j < 8; j++)
      do_op(0, RET, 0, 8'h00, 16'h0000,
            (j == 7) ? 16'h0022 : 16'(16'h1000 + (6 - j) * 16 + 1),
            0, (j == 7), 1, $sformatf("unwind%0d", j));
    do_op(0, INC, 0, 8'h00, 16'h0000, 16'h0023, 0, 1, 1, "err_sticky");

    async_reset("reset_clears_err");
    release_reset();
    do_op(0, RET, 0, 8'h00, 16'h0000, 16'h0000, 0, 1, 1, "ret_on_empty");
    do_op(0, INC, 0, 8'h00, 16'h0000, 16'h0001, 0, 1, 1, "err_persist");

    do_op(0, LOAD_IMM, 0, 8'h40, 16'h0000, 16'h0040, 0, 1, 1, "load_40");
    do_op(1, INC, 0, 8'h00, 16'h0000, 16'h0040, 0, 1, 1, "stall_inc");
    do_op(0, CALL, 0, 8'h00, 16'h0200, 16'h0200, 0, 0, 1, "call_200");
    do_op(1, CALL, 0, 8'h00, 16'h0300, 16'h0200, 0, 0, 1, "stall_call");
    do_op(1, RET, 0, 8'h00, 16'h0000, 16'h0200, 0, 0, 1, "stall_ret");
    do_op(0, RET, 0, 8'h00, 16'h0000, 16'h0041, 0, 1, 1, "ret_after_stall");

    do_op(0, CALL, 0, 8'h00, 16'h0500, 16'h0500, 0, 0, 1, "d3_call0");
    do_op(0, CALL, 0, 8'h00, 16'h0600, 16'h0600, 0, 0, 1, "d3_call1");
    do_op(0, CALL, 0, 8'h00, 16'h0700, 16'h0700, 0, 0, 1, "d3_call2");
    async_reset("midcycle_reset");
    do_op(1, INC, 0, 8'h00, 16'h0000, 16'h0000, 0, 1, 0, "reset_during_stall");
    release_reset();
    do_op(0, RET, 0, 8'h00, 16'h0000, 16'h0000, 0, 1, 1, "depth_cleared");

    repeat (3) @(posedge clk);
    #2;
    done = 1'b1;
  end

endmodule
